// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: widths, reset PC and FSM encoding.
// PC_WIDTH may be overridden from the command line with +define+PC_WIDTH=<n>.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package fetch_unit_pkg;

  localparam int PC_WIDTH    = `PC_WIDTH;
  localparam int INSTR_WIDTH = 32;

  // First fetch address after reset (truncated to PC_W where used)
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect source selection for the fetch unit.
// The EX-stage branch/jr redirect belongs to an older instruction than the
// ID-stage jal, so it wins when both fire together. Targets are word-aligned.

module fetch_redirect_mux
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_WIDTH
) (
  input  logic            jal_change_pc,
  input  logic [PC_W-1:0] jal_pc,
  input  logic            br_change_pc,
  input  logic [PC_W-1:0] br_pc,
  output logic            redirect,
  output logic [PC_W-1:0] target
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(2'b11));

  logic [PC_W-1:0] raw_target;

  // Pick the redirect source (branch over jal) and force word alignment
  always_comb begin
    raw_target = {PC_W{1'b0}};
    redirect   = 1'b0;
    if (br_change_pc) begin
      raw_target = br_pc;
      redirect   = 1'b1;
    end else if (jal_change_pc) begin
      raw_target = jal_pc;
      redirect   = 1'b1;
    end else begin
      raw_target = {PC_W{1'b0}};
      redirect   = 1'b0;
    end
    target = raw_target & ALIGN_MASK;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage PC and instruction-fetch unit.
// Owns the architectural PC, issues req/ack fetches to instruction memory and
// registers {valid, pc, instr} into the IF/ID boundary. Redirects from jal (ID)
// and branch/jr (EX) squash wrong-path fetches; an in-flight request that a
// redirect overtakes is marked to be dropped when its ack arrives.
// Optional feature: define FETCH_SKID_BUF_EN to keep a word acked during a
// stall in a one-entry skid buffer instead of re-fetching it.

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = PC_WIDTH,
  parameter int              INSTR_W  = INSTR_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               if_i_clk,
  input  logic               if_i_rst,
  input  logic               if_i_stall,
  input  logic               if_i_jal_change_pc,
  input  logic [PC_W-1:0]    if_i_jal_pc,
  input  logic               if_i_br_change_pc,
  input  logic [PC_W-1:0]    if_i_br_pc,
  output logic               if_o_imem_req,
  output logic [PC_W-1:0]    if_o_imem_addr,
  input  logic               if_i_imem_ack,
  input  logic [INSTR_W-1:0] if_i_imem_rdata,
  output logic               if_o_valid,
  output logic [PC_W-1:0]    if_o_pc,
  output logic [INSTR_W-1:0] if_o_instr,
  output logic               if_o_busy
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    addr_q;
  logic [PC_W-1:0]    addr_d;
  logic               drop_q;
  logic               drop_d;
  logic               valid_q;
  logic               valid_d;
  logic [PC_W-1:0]    ifid_pc_q;
  logic [PC_W-1:0]    ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic               issue;
  logic               redirect;
  logic [PC_W-1:0]    target;
  logic               ack_ok;
`ifdef FETCH_SKID_BUF_EN
  logic [PC_W-1:0]    skid_pc_q;
  logic [PC_W-1:0]    skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q;
  logic [INSTR_W-1:0] skid_instr_d;
`endif

  fetch_redirect_mux #(
    .PC_W(PC_W)
  ) u_redirect_mux (
    .jal_change_pc (if_i_jal_change_pc),
    .jal_pc        (if_i_jal_pc),
    .br_change_pc  (if_i_br_change_pc),
    .br_pc         (if_i_br_pc),
    .redirect      (redirect),
    .target        (target)
  );

  // An ack only means something while a request is presented
  assign ack_ok = if_i_imem_ack && (state_q == S_REQ);

  // FSM state register
  always_ff @(posedge if_i_clk or posedge if_i_rst) begin
    if (if_i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a clean ack under stall parks in S_HOLD; redirect or unstall leaves it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (ack_ok && !drop_q && if_i_stall) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect || !if_i_stall) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: the request (and busy) is presented for the whole of S_REQ
  always_comb begin
    if (state_q == S_REQ) begin
      if_o_imem_req = 1'b1;
      if_o_busy     = 1'b1;
    end else begin
      if_o_imem_req = 1'b0;
      if_o_busy     = 1'b0;
    end
  end

  // Datapath next values: PC, drop flag, IF/ID entry, skid buffer and request address
  always_comb begin
    pc_d         = pc_q;
    drop_d       = drop_q;
    valid_d      = valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    issue        = 1'b0;
`ifdef FETCH_SKID_BUF_EN
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    case (state_q)
      S_IDLE: begin
        issue = 1'b1;
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (!if_i_stall) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      S_REQ: begin
        if (redirect) begin
          // Redirect beats stall and any same-cycle ack; the acked word is discarded
          pc_d    = target;
          valid_d = 1'b0;
          if (ack_ok) begin
            drop_d = 1'b0;
            issue  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end else if (ack_ok) begin
          if (drop_q) begin
            // Wrong-path word: discard and fetch the redirect target
            drop_d = 1'b0;
            issue  = 1'b1;
            if (!if_i_stall) begin
              valid_d = 1'b0;
            end else begin
              valid_d = valid_q;
            end
          end else if (!if_i_stall) begin
            valid_d      = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_instr_d = if_i_imem_rdata;
            pc_d         = pc_q + PC_STEP;
            issue        = 1'b1;
          end else begin
`ifdef FETCH_SKID_BUF_EN
            skid_pc_d    = pc_q;
            skid_instr_d = if_i_imem_rdata;
            pc_d         = pc_q + PC_STEP;
`else
            // Word discarded; the same PC is fetched again once decode frees up
            pc_d = pc_q;
`endif
          end
        end else if (!if_i_stall) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          issue   = 1'b1;
`ifdef FETCH_SKID_BUF_EN
          skid_pc_d    = {PC_W{1'b0}};
          skid_instr_d = {INSTR_W{1'b0}};
`endif
        end else if (!if_i_stall) begin
          issue = 1'b1;
`ifdef FETCH_SKID_BUF_EN
          valid_d      = 1'b1;
          ifid_pc_d    = skid_pc_q;
          ifid_instr_d = skid_instr_q;
          skid_pc_d    = {PC_W{1'b0}};
          skid_instr_d = {INSTR_W{1'b0}};
`else
          valid_d = 1'b0;
`endif
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        pc_d    = RESET_PC;
        drop_d  = 1'b0;
        valid_d = 1'b0;
        issue   = 1'b0;
      end
    endcase
    // A new request always starts at the post-update PC; otherwise address holds
    if (issue) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath registers
  always_ff @(posedge if_i_clk or posedge if_i_rst) begin
    if (if_i_rst) begin
      pc_q         <= RESET_PC;
      addr_q       <= {PC_W{1'b0}};
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      ifid_pc_q    <= {PC_W{1'b0}};
      ifid_instr_q <= {INSTR_W{1'b0}};
`ifdef FETCH_SKID_BUF_EN
      skid_pc_q    <= {PC_W{1'b0}};
      skid_instr_q <= {INSTR_W{1'b0}};
`endif
    end else begin
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
`ifdef FETCH_SKID_BUF_EN
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`endif
    end
  end

  assign if_o_imem_addr = addr_q;
  assign if_o_valid     = valid_q;
  assign if_o_pc        = ifid_pc_q;
  assign if_o_instr     = ifid_instr_q;

endmodule
